// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall merge, exception/eret redirect sequencing, EPC/cause holding.
// Optional stuck-stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE     = 32'h0000_0020,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [7:0]  WDOG_LIMIT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] epc_o,
    output logic [4:0]  cause_o,
    output logic        busy
);
    localparam logic [4:0] ERET_CODE = 5'h0E;
    localparam logic [4:0] WDOG_CODE = 5'h1F;
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    state_t      state_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic [31:0] epc_q;
    logic [4:0]  cause_q;
    logic [3:0]  drain_q;
    logic [5:0]  req_stall;
    logic        ext_acc;
    logic        wdog_hit;
    logic        accept;

    assign ext_acc = (state_q == IDLE) && exc_valid;
    assign accept  = ext_acc || wdog_hit;

`ifdef PIPE_CTRL_WDOG_EN
    logic [7:0] wdog_q;
    logic       any_req;
    assign any_req  = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
    assign wdog_hit = (state_q == IDLE) && !exc_valid && any_req && (wdog_q == WDOG_LIMIT - 8'd1);
    // Count consecutive stalled IDLE cycles; any accepted exception restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdog_q <= 8'd0;
        else if (state_q == IDLE)
            wdog_q <= (accept || !any_req) ? 8'd0 : wdog_q + 8'd1;
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Highest requesting stage freezes itself and everything upstream
    always_comb begin
        req_stall = stallreq_mem ? 6'b011111 :
                    stallreq_ex  ? 6'b001111 :
                    stallreq_id  ? 6'b000111 :
                    stallreq_if  ? 6'b000011 : 6'b000000;
        stall     = !rst              ? 6'b000000 :
                    state_q == FLUSH  ? 6'b000000 :
                    accept            ? 6'b111111 : req_stall;
    end

    // Exception/eret sequencer: accept in IDLE, one flush cycle, then drain out flushed reports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
            epc_q    <= 32'd0;
            cause_q  <= 5'd0;
            drain_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                        if (ext_acc && exc_code == ERET_CODE) begin
                            new_pc_q <= epc_q;
                        end else begin
                            new_pc_q <= EXC_BASE;
                            epc_q    <= exc_pc_i;
                            cause_q  <= ext_acc ? exc_code : WDOG_CODE;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DRAIN;
                    flush_q <= 1'b0;
                    drain_q <= DRAIN_INIT;
                end
                DRAIN: begin
                    if (drain_q == 4'd0)
                        state_q <= IDLE;
                    else
                        drain_q <= drain_q - 4'd1;
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush   = flush_q;
    assign new_pc  = new_pc_q;
    assign epc_o   = epc_q;
    assign cause_o = cause_q;
    assign busy    = state_q != IDLE;
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by the PC and pipeline registers. It sequences exception entry and `eret` return through a registered flush and redirect (`flush` and `new_pc` to the PC), and holds EPC/cause. An optional watchdog converts a stuck stall into an exception.

## Interface
Parameters:
- `EXC_BASE`, 32'h0000_0020, exception vector loaded into `new_pc` on exception entry.
- `DRAIN_CYCLES`, 2, cycles after flush during which `exc_valid` is ignored (range 1–15).
- `WDOG_LIMIT`, 8'd255, consecutive stalled cycles that trigger the watchdog exception.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stallreq_if` in 1: fetch stall request.
- `stallreq_id` in 1: decode stall request.
- `stallreq_ex` in 1: execute stall request (multi-cycle mul/div).
- `stallreq_mem` in 1: memory stall request.
- `exc_valid` in 1: MEM stage reports an exception or `eret`.
- `exc_code` in 5: cause code. 5'h0E = `eret`; any other value = exception.
- `exc_pc_i` in 32: PC of the faulting MEM-stage instruction.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- `flush` out 1: one-cycle pipeline flush; PC loads `new_pc`.
- `new_pc` out 32: redirect target, valid while `flush`=1.
- `epc_o` out 32: saved exception PC.
- `cause_o` out 5: last accepted cause code.
- `busy` out 1: 1 whenever state ≠ IDLE.

## Operation
States: IDLE, FLUSH, DRAIN.

IDLE:
- `stall` is combinational from the requests; the highest stage wins.
- mem → 6'b011111, ex → 6'b001111, id → 6'b000111, if → 6'b000011, none → 6'b000000.
- `exc_valid`=1 is accepted this cycle:
  - `stall` is forced to 6'b111111 that cycle.
  - Go to FLUSH.
  - Non-`eret`: `epc_o`<=`exc_pc_i`, `cause_o`<=`exc_code`, `new_pc`<=`EXC_BASE`.
  - `eret`: `new_pc`<=`epc_o`; EPC and cause are unchanged.

FLUSH (exactly 1 cycle):
- `flush`=1, `stall`=0. Go to DRAIN and load the drain counter with `DRAIN_CYCLES`-1.

DRAIN:
- `flush`=0. `stall` is computed as in IDLE. `exc_valid` is ignored because it comes from flushed instructions.
- The counter decrements each cycle; at 0 go to IDLE.

General rules:
- Simultaneous `exc_valid` and stall requests in IDLE: the exception wins.
- Reset mid-sequence returns to IDLE immediately.

## Timing
- Reset values:
  - `stall`=0, `flush`=0, `new_pc`=0, `epc_o`=0, `cause_o`=0, `busy`=0.
  - State IDLE; drain counter 0; watchdog counter 0.
- Stall path latency: 0 cycles (combinational).
- Redirect latency:
  - `exc_valid` sampled at edge N.
  - `flush`=1 during cycle N→N+1.
  - The PC loads `new_pc` at edge N+1.
- `busy` rises the cycle after acceptance and stays high through FLUSH and DRAIN (1+`DRAIN_CYCLES` cycles).
- Back-to-back: a new exception is accepted no earlier than the first IDLE cycle.
- `eret` with no prior exception redirects to `epc_o`=0.

## Configuration
- `PIPE_CTRL_WDOG_EN` defined:
  - An 8-bit counter increments each IDLE cycle in which any stall request is active, and clears when none is active.
  - On reaching `WDOG_LIMIT`, an internal exception is accepted exactly like `exc_valid` with cause 5'h1F and `epc_o`<=`exc_pc_i`. The counter then clears.
  - External `exc_valid` in the same cycle takes priority; the watchdog counter also clears in that case.
- `PIPE_CTRL_WDOG_EN` undefined: no counter; the stall requests only drive `stall`.

## Test plan
- Reset: drive `rst`=0 mid-FLUSH → all outputs 0, state IDLE, on the same cycle without waiting for a clock.
- Stall priority: `stallreq_id`=1 and `stallreq_mem`=1 → `stall`=6'b011111. `stallreq_if` alone → 6'b000011.
- Exception entry: `exc_valid`=1, code 5'h0C, `exc_pc_i`=32'h0000_0104 →
  - acceptance cycle: `stall`=6'b111111;
  - next cycle: `flush`=1, `new_pc`=32'h0000_0020;
  - `epc_o`=32'h0000_0104, `cause_o`=5'h0C.
- Drain masking: `exc_valid` held high for 4 cycles → exactly one flush pulse; with `DRAIN_CYCLES`=2, the second accept occurs at cycle 4.
- Return: after the entry above, `exc_valid` with code 5'h0E → `flush`=1, `new_pc`=32'h0000_0104; `epc_o` unchanged.
- Watchdog (macro on, `WDOG_LIMIT`=8'd10): hold `stallreq_ex`=1 for 10 cycles → flush with `new_pc`=32'h0000_0020 and `cause_o`=5'h1F. With the macro off: no flush after 300 cycles.
